// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the pipelined add/subtract unit:
//   MODE_ADD / MODE_SUB : encodings of the in_mode operation select.
//   seg_ok()            : legality check for the N / SEG slicing parameters.
// -----------------------------------------------------------------------------
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // The operand must split into a whole number of equal, non-empty slices.
  function automatic bit seg_ok(input int n, input int seg);
    return (seg > 0) && (n >= seg) && ((n % seg) == 0);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// -----------------------------------------------------------------------------
// addsub_slice
// SEG-bit combinational adder with carry-in and carry-out; one per stage.
// Ports:
//   i_a, i_b  : SEG-bit operand slices (i_b already conditioned for subtract)
//   i_cin     : carry into this slice
//   o_sum     : SEG-bit sum slice
//   o_cout    : carry out of this slice
// -----------------------------------------------------------------------------
module addsub_slice #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout
);

  logic [SEG:0] w_full;

  assign w_full          = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_cin};
  assign {o_cout, o_sum} = w_full;

endmodule

// File: rtl/addsub_pipe.sv
// -----------------------------------------------------------------------------
// addsub_pipe
// Pipelined N-bit add/subtract. The operands are cut into STAGES = N/SEG
// slices; stage k adds slice k and hands its carry to stage k+1 through a
// register. One operation per cycle, valid/ready handshake on both sides.
// Ports:
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready : operand beat handshake (in_ready is the advance)
//   in_mode             : 0 = A+B, 1 = A-B
//   in_a, in_b          : N-bit operands
//   out_valid/out_ready : result beat handshake
//   out_z               : result modulo 2^N
//   out_cout            : carry out (subtract: 1 = no borrow, A >= B)
//   out_ovf             : two's-complement signed overflow
//   out_zero            : out_z == 0
// -----------------------------------------------------------------------------
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int N   = 32,
  parameter int SEG = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_z,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         out_zero
);

  localparam int STAGES = N / SEG;

  if (!seg_ok(N, SEG)) begin : g_bad_params
    $error("addsub_pipe: N must be a non-zero multiple of SEG");
  end

  // Single global advance: the whole pipe shifts together or holds together,
  // so a stalled result can never be overwritten by a beat behind it.
  logic w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage inputs: the operand ports for stage 0, the previous stage's
    // registers otherwise.
    logic [N-1:0]   w_a_in;
    logic [N-1:0]   w_b_in;
    logic [N-1:0]   w_z_in;
    logic           w_c_in;
    logic           w_v_in;
    logic [SEG-1:0] w_sum;
    logic           w_cout;
    logic [N-1:0]   w_z_next;

    // Stage registers. A and B' travel at full width: the slices above k are
    // the skew operands still to be added, and bit N-1 carries the sign bits
    // needed for overflow at the end of the pipe.
    logic           r_v;
    logic           r_c;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_z;

    if (k == 0) begin : g_first
      // Subtract is A + ~B + 1: invert B here and inject the +1 as carry-in.
      // The mode is fully absorbed at this point, so it is not carried on.
      assign w_a_in = in_a;
      assign w_b_in = (in_mode == MODE_SUB) ? ~in_b : in_b;
      assign w_c_in = (in_mode == MODE_SUB);
      assign w_z_in = '0;
      assign w_v_in = in_valid;
    end else begin : g_next
      assign w_a_in = g_stage[k-1].r_a;
      assign w_b_in = g_stage[k-1].r_b;
      assign w_c_in = g_stage[k-1].r_c;
      assign w_z_in = g_stage[k-1].r_z;
      assign w_v_in = g_stage[k-1].r_v;
    end

    addsub_slice #(
      .SEG (SEG)
    ) u_slice (
      .i_a    (w_a_in[k*SEG +: SEG]),
      .i_b    (w_b_in[k*SEG +: SEG]),
      .i_cin  (w_c_in),
      .o_sum  (w_sum),
      .o_cout (w_cout)
    );

    // Lower slices pass through untouched; slice k is filled in here.
    // NOTE: combinational blocks use blocking '=' with a full default first,
    // so every bit has a value on every path and no latch is inferred.
    always_comb begin
      w_z_next               = w_z_in;
      w_z_next[k*SEG +: SEG] = w_sum;
    end

    // NOTE: the datapath registers are reset along with the valid bits so a
    // discarded operation can never leak a partial result onto out_z.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        // NOTE: sequential state uses non-blocking '<=' so every stage
        // samples its neighbour's pre-edge value.
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_a <= '0;
        r_b <= '0;
        r_z <= '0;
      end else if (w_adv) begin
        r_v <= w_v_in;
        r_c <= w_cout;
        r_a <= w_a_in;
        r_b <= w_b_in;
        r_z <= w_z_next;
      end
    end
  end

  // Final stage view.
  logic         w_v_last;
  logic [N-1:0] w_z_last;
  logic         w_sign_a;
  logic         w_sign_b;
  logic         w_sign_z;

  assign w_v_last = g_stage[STAGES-1].r_v;
  assign w_z_last = g_stage[STAGES-1].r_z;
  assign w_sign_a = g_stage[STAGES-1].r_a[N-1];
  assign w_sign_b = g_stage[STAGES-1].r_b[N-1];
  assign w_sign_z = w_z_last[N-1];

  assign w_adv     = ~w_v_last | out_ready;
  assign in_ready  = w_adv;

  assign out_valid = w_v_last;
  assign out_z     = w_z_last;
  assign out_cout  = g_stage[STAGES-1].r_c;
  // Flags are qualified by valid: an all-zero reset image must not read as
  // a zero result.
  assign out_ovf   = w_v_last & (w_sign_a == w_sign_b) & (w_sign_z != w_sign_a);
  assign out_zero  = w_v_last & ~|w_z_last;

endmodule

// File: tb/tb_addsub_pipe.sv
module tb_addsub_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // N=32, SEG=8 instance
  logic        in_valid, in_ready, in_mode;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [31:0] out_z;
  logic        out_cout, out_ovf, out_zero;

  // N=16, SEG=16 instance (single stage)
  logic        s_in_valid, s_in_ready, s_in_mode;
  logic [15:0] s_in_a, s_in_b;
  logic        s_out_valid, s_out_ready;
  logic [15:0] s_out_z;
  logic        s_out_cout, s_out_ovf, s_out_zero;

  addsub_pipe #(.N(32), .SEG(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  addsub_pipe #(.N(16), .SEG(16)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_mode   (s_in_mode),
    .in_a      (s_in_a),
    .in_b      (s_in_b),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_z     (s_out_z),
    .out_cout  (s_out_cout),
    .out_ovf   (s_out_ovf),
    .out_zero  (s_out_zero)
  );

  typedef struct {
    logic [31:0] z;
    bit          c;
    bit          o;
    bit          zr;
  } res_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  int   pat_mode = 0;          // 0 = out_ready driven by main, 1 = 1,0,0,1, 2 = random
  bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  res_t sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input int n, input longint unsigned a_i,
                                 input longint unsigned b_i, input bit mode);
    res_t              r;
    longint unsigned   m, a, b, full;
    longint            sa, sbv, res, lim;
    m   = (64'd1 << n) - 1;
    a   = a_i & m;
    b   = b_i & m;
    if (mode) begin
      full = (a - b) & m;
      r.c  = (a >= b);
    end else begin
      full = a + b;
      r.c  = ((full >> n) & 64'd1) != 0;
      full = full & m;
    end
    lim  = longint'(64'd1 << (n - 1));
    sa   = (a >= 64'(lim)) ? longint'(a) - 2 * lim : longint'(a);
    sbv  = (b >= 64'(lim)) ? longint'(b) - 2 * lim : longint'(b);
    res  = mode ? sa - sbv : sa + sbv;
    r.o  = (res > lim - 1) || (res < -lim);
    r.z  = full[31:0];
    r.zr = (full == 0);
    return r;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] edge_vals [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // out_ready pattern generator, changes just after the rising edge.
  always @(posedge clk) begin
    if (pat_mode != 0) begin
      #1;
      if (pat_mode == 1) out_ready = pat[cyc % 4];
      else               out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: handshake rule, hold-while-stalled, in-order scoreboard.
  bit          prev_stall = 0;
  logic [31:0] p_z;
  logic        p_c, p_o, p_zr, p_v;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'(p_v));
        check("hold_z",     64'(out_z),     64'(p_z));
        check("hold_cout",  64'(out_cout),  64'(p_c));
        check("hold_ovf",   64'(out_ovf),   64'(p_o));
        check("hold_zero",  64'(out_zero),  64'(p_zr));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(out_valid), 64'(0));
        end else begin
          res_t r;
          r = sb.pop_front();
          check("sb_z",    64'(out_z),    64'(r.z));
          check("sb_cout", 64'(out_cout), 64'(r.c));
          check("sb_ovf",  64'(out_ovf),  64'(r.o));
          check("sb_zero", 64'(out_zero), 64'(r.zr));
        end
      end
      prev_stall = out_valid && !out_ready;
      p_v  = out_valid;
      p_z  = out_z;
      p_c  = out_cout;
      p_o  = out_ovf;
      p_zr = out_zero;
    end
  end

  // Present one beat, wait (bounded) for acceptance, log expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit mode);
    bit ok = 0;
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) check("accept_timeout", 64'(in_ready), 64'(1));
    else begin
      sb.push_back(model(32, 64'(a), 64'(b), mode));
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input bit mode, input logic [31:0] ez, input bit ec,
                         input bit eo, input bit ezr);
    int lat = -1;
    send(a, b, mode);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat),      64'(4));
    check({tag, "_z"},       64'(out_z),    64'(ez));
    check({tag, "_cout"},    64'(out_cout), 64'(ec));
    check({tag, "_ovf"},     64'(out_ovf),  64'(eo));
    check({tag, "_zero"},    64'(out_zero), 64'(ezr));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
    #1 check("drain_pending", 64'(sb.size()), 64'(0));
  endtask

  // Single-stage instance: one beat, one-cycle latency.
  task automatic s_run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input bit mode, input res_t e);
    int lat = -1;
    s_in_a     = a;
    s_in_b     = b;
    s_in_mode  = mode;
    s_in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(s_in_ready), 64'(1));
    acc_cyc = cyc;
    @(posedge clk);
    #1 s_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_out_valid) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat),        64'(1));
    check({tag, "_z"},       64'(s_out_z),    64'(e.z));
    check({tag, "_cout"},    64'(s_out_cout), 64'(e.c));
    check({tag, "_ovf"},     64'(s_out_ovf),  64'(e.o));
    check({tag, "_zero"},    64'(s_out_zero), 64'(e.zr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    res_t e;
    in_valid    = 1'b0;
    in_mode     = 1'b0;
    in_a        = '0;
    in_b        = '0;
    out_ready   = 1'b1;
    s_in_valid  = 1'b0;
    s_in_mode   = 1'b0;
    s_in_a      = '0;
    s_in_b      = '0;
    s_out_ready = 1'b1;

    // Reset state
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_z",     64'(out_z),     64'(0));
    check("rst_out_cout",  64'(out_cout),  64'(0));
    check("rst_out_ovf",   64'(out_ovf),   64'(0));
    check("rst_out_zero",  64'(out_zero),  64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases, no backpressure
    run_one("add_ff_1",    32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    run_one("sub_5_7",     32'd5,         32'd7,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one("sub_7_7",     32'd7,         32'd7,         1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_one("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Back-to-back 8 beats, alternating modes, out_ready 1,0,0,1,...
    pat_mode = 1;
    for (int i = 0; i < 8; i++) send(pick(), pick(), i[0]);
    drain();

    // Random traffic with random backpressure and input gaps
    pat_mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(pick(), pick(), 1'($urandom_range(0, 1)));
    end
    drain();
    @(posedge clk);
    #2;
    pat_mode  = 0;
    out_ready = 1'b1;

    // Reset with 3 beats in flight
    send(32'h1111_1111, 32'h2222_2222, 1'b0);
    send(32'h3333_3333, 32'h0000_0001, 1'b1);
    send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_z",     64'(out_z),     64'(0));
    check("midrst_out_cout",  64'(out_cout),  64'(0));
    check("midrst_out_ovf",   64'(out_ovf),   64'(0));
    check("midrst_out_zero",  64'(out_zero),  64'(0));
    check("midrst_in_ready",  64'(in_ready),  64'(1));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_one("post_rst_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1 check("post_rst_no_stale", 64'(sb.size()), 64'(0));

    // Single-stage configuration
    e.z = 32'h1000; e.c = 1'b1; e.o = 1'b0; e.zr = 1'b0;
    s_run("s1_sub", 16'h1234, 16'h0234, 1'b1, e);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] a, b;
      bit          m;
      a = 16'($urandom);
      b = 16'($urandom);
      m = 1'($urandom_range(0, 1));
      s_run("s1_rand", a, b, m, model(16, 64'(a), 64'(b), m));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global safety net
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
Parametrised, pipelined N-bit add/subtract unit; successor to the single-cycle combinational subtractor. Operands split into SEG-bit slices, one slice per stage, carry rippled stage-to-stage through registers. Throughput one operation per cycle, valid/ready on both sides. Sits between the register-file read stage and ALU result mux in the multi-cycle datapath.

Parameters:
N, 32, operand/result width in bits; N % SEG == 0 required.
SEG, 8, slice width per stage; STAGES = N/SEG (default 4).

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  unit accepts beat this cycle
in_mode  in  1  0 = add (A+B), 1 = subtract (A-B)
in_a  in  N  operand A
in_b  in  N  operand B
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result
out_z  out  N  result, modulo 2^N
out_cout  out  1  carry out; in subtract mode 1 = no borrow (A >= B unsigned)
out_ovf  out  1  two's-complement signed overflow
out_zero  out  1  out_z == 0

Behaviour:
- Subtract implemented as A + ~B + 1: stage 0 carry-in = in_mode, B slices XORed with in_mode.
- Stage k (0..STAGES-1) adds slice k of A and B' plus registered carry from stage k-1; stores sum slice, carry, valid bit, mode, sign bits of A and B'; unconsumed upper slices of A and B' travel with it (skew registers).
- Global advance: adv = ~out_valid | out_ready. All stages shift when adv = 1; all hold when adv = 0. in_ready = adv (combinational, no dependency on in_valid).
- Beat accepted when in_valid & in_ready. Bubbles (in_valid = 0 on advance) enter as valid = 0 and propagate.
- Latency: exactly STAGES cycles from acceptance edge to out_valid with no backpressure; STAGES = 1 gives one registered cycle.
- out_cout = carry out of top slice. out_ovf = (signA == signB') & (signZ != signA). out_zero computed on full assembled out_z at final stage.
- While out_valid & ~out_ready: out_z, out_cout, out_ovf, out_zero held stable, no new beat accepted, no in-flight data lost.
- Results emerge in acceptance order; no reordering, no drops.
- Reset (async, any cycle): all stage valid bits, carries and data registers clear to 0; out_valid=0, out_z=0, out_cout=0, out_ovf=0, out_zero=0 immediately; in_ready=1 during and after reset. In-flight operations discarded, no partial result ever shown.
- Wrap-around: results modulo 2^N; no saturation.

Decomposition:
- Shared package addsub_pkg: MODE_ADD = 1'b0, MODE_SUB = 1'b1; width-check constant/function for N % SEG.
- One sub-module: addsub_slice (SEG-bit combinational add with carry-in/carry-out), instantiated STAGES times via generate; pipeline registers and handshake in addsub_pipe.

Test Plan:
- N=32, SEG=8: add 0x0000_00FF + 0x0000_0001, no backpressure -> out_valid exactly 4 cycles after acceptance, out_z=0x0000_0100, cout=0, ovf=0, zero=0.
- Subtract 5 - 7 -> out_z=0xFFFF_FFFE, cout=0 (borrow), ovf=0; subtract 7 - 7 -> out_z=0, cout=1, zero=1.
- Add 0x7FFF_FFFF + 1 -> out_z=0x8000_0000, ovf=1, cout=0; subtract 0x8000_0000 - 1 -> 0x7FFF_FFFF, ovf=1, cout=1.
- Back-to-back 8 beats (alternating modes) with out_ready toggled 1,0,0,1,...: every result matches reference model in order, outputs stable while stalled, in_ready low exactly when out_valid & ~out_ready.
- Assert rst mid-stream with 3 beats in flight -> out_valid=0 and all outputs 0 same cycle; after release, next accepted beat 0xFFFF_FFFF + 1 -> out_z=0, cout=1, zero=1 after 4 cycles; no stale result appears.
- N=16, SEG=16 (STAGES=1): 0x1234 - 0x0234 -> 0x1000, cout=1, latency 1 cycle.
